// File: rtl/parity_frame_checker.sv
// Serial receive-side parity checker: collects DATA_W data bits (LSB first) plus one
// parity bit, then reports the word with a one-cycle valid pulse and parity-error flag.
module parity_frame_checker #(
   parameter int unsigned DATA_W = 3,
   parameter int unsigned ODD    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err
);

   localparam int unsigned     CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
   localparam logic            ODD_B = (ODD != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   sr_q, sr_d;
   logic                acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                parity_err_q, parity_err_d;
   logic                busy_q, busy_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sr_q         <= '0;
         acc_q        <= 1'b0;
         cnt_q        <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and output logic; start restarts the frame from any state
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      parity_err_d = 1'b0;

      if (start) begin
         state_d = S_DATA;
         sr_d    = '0;
         acc_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_DATA: begin
               if (bit_valid) begin
                  for (int unsigned i = 0; i < DATA_W; i++) begin
                     if (cnt_q == CNT_W'(i)) begin
                        sr_d[i] = bit_in;
                     end
                  end
                  acc_d = acc_q ^ bit_in;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST) begin
                     state_d = S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               if (bit_valid) begin
                  data_out_d   = sr_q;
                  data_valid_d = 1'b1;
                  parity_err_d = acc_q ^ bit_in ^ ODD_B;
                  state_d      = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   assign busy       = busy_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench: even- and odd-parity instances share stimulus; results are
// compared against a word/parity reference model built from $countones.
module tb_parity_frame_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       bit_in;
   logic       bit_valid;
   logic       busy0, busy1;
   logic [2:0] data_out0, data_out1;
   logic       data_valid0, data_valid1;
   logic       parity_err0, parity_err1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2:0] last_w = 3'b000;

   always #5 clk = ~clk;

   parity_frame_checker #(.DATA_W(3), .ODD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .busy(busy0), .data_out(data_out0), .data_valid(data_valid0), .parity_err(parity_err0)
   );

   parity_frame_checker #(.DATA_W(3), .ODD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .busy(busy1), .data_out(data_out1), .data_valid(data_valid1), .parity_err(parity_err1)
   );

   function automatic logic model_err(input logic [2:0] w, input logic p, input int odd);
      return ((($countones(w) + int'(p)) % 2) != odd);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge
   task automatic step(input logic s, input logic b, input logic v);
      start     = s;
      bit_in    = b;
      bit_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic stall(input int unsigned max_stall);
      int unsigned k;
      k = (max_stall == 0) ? 0 : $urandom_range(max_stall, 0);
      repeat (k) begin
         step(1'b0, 1'($urandom % 2), 1'b0);
         chk("stall_busy", 32'(busy0), 1);
         chk("stall_valid", 32'(data_valid0), 0);
      end
   endtask

   task automatic chk_result(input logic [2:0] w, input logic p);
      chk("valid0", 32'(data_valid0), 1);
      chk("valid1", 32'(data_valid1), 1);
      chk("data0", 32'(data_out0), 32'(w));
      chk("data1", 32'(data_out1), 32'(w));
      chk("perr_even", 32'(parity_err0), 32'(model_err(w, p, 0)));
      chk("perr_odd", 32'(parity_err1), 32'(model_err(w, p, 1)));
      chk("busy_done0", 32'(busy0), 0);
      chk("busy_done1", 32'(busy1), 0);
      last_w = w;
   endtask

   task automatic send_frame(input logic [2:0] w, input logic p, input int unsigned max_stall);
      step(1'b1, 1'b0, 1'b0);
      chk("start_busy", 32'(busy0), 1);
      chk("pulse_single", 32'(data_valid0), 0);
      chk("data_hold", 32'(data_out0), 32'(last_w));
      for (int i = 0; i < 3; i++) begin
         stall(max_stall);
         step(1'b0, w[i], 1'b1);
         chk("bit_busy", 32'(busy0), 1);
         chk("bit_valid_low", 32'(data_valid1), 0);
      end
      stall(max_stall);
      step(1'b0, p, 1'b1);
      chk_result(w, p);
   endtask

   initial begin
      int n_valid;
      logic [2:0] w;
      logic       p;

      rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_data", 32'(data_out0), 0);
      chk("rst_valid", 32'(data_valid0), 0);
      chk("rst_perr", 32'(parity_err1), 0);
      #2 rst_n = 1'b1;

      // Directed even-parity frames
      send_frame(3'b101, 1'b0, 0);
      send_frame(3'b111, 1'b0, 0);
      send_frame(3'b111, 1'b1, 0);
      send_frame(3'b101, 1'b0, 5);

      // Abort: start while a bit is valid discards that bit and restarts
      n_valid = 0;
      step(1'b1, 1'b0, 1'b0); n_valid += int'(data_valid0);
      step(1'b0, 1'b1, 1'b1); n_valid += int'(data_valid0);
      step(1'b0, 1'b1, 1'b1); n_valid += int'(data_valid0);
      step(1'b1, 1'b1, 1'b1); n_valid += int'(data_valid0);
      chk("abort_busy", 32'(busy0), 1);
      chk("abort_data_hold", 32'(data_out0), 32'(last_w));
      step(1'b0, 1'b0, 1'b1); n_valid += int'(data_valid0);
      step(1'b0, 1'b1, 1'b1); n_valid += int'(data_valid0);
      step(1'b0, 1'b1, 1'b1); n_valid += int'(data_valid0);
      step(1'b0, 1'b0, 1'b1); n_valid += int'(data_valid0);
      chk_result(3'b110, 1'b0);
      step(1'b0, 1'b0, 1'b0); n_valid += int'(data_valid0);
      chk("abort_pulses", 32'(n_valid), 1);

      // Reset mid-frame, then bits without start must be ignored
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy0), 0);
      chk("mid_rst_data", 32'(data_out0), 0);
      chk("mid_rst_valid", 32'(data_valid0), 0);
      chk("mid_rst_perr", 32'(parity_err0), 0);
      step(1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      last_w = 3'b000;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'($urandom % 2), 1'b1);
         chk("nostart_valid", 32'(data_valid0), 0);
         chk("nostart_busy", 32'(busy1), 0);
      end

      // Exhaustive odd-parity frames back-to-back, correct then inverted parity
      for (int i = 0; i < 8; i++) begin
         w = 3'(i);
         send_frame(w, ~^w, 0);
         chk("odd_ok", 32'(parity_err1), 0);
      end
      for (int i = 0; i < 8; i++) begin
         w = 3'(i);
         send_frame(w, ^w, 0);
         chk("odd_bad", 32'(parity_err1), 1);
      end

      // Random frames with random stalls
      for (int i = 0; i < 12; i++) begin
         w = 3'($urandom % 8);
         p = 1'($urandom % 2);
         send_frame(w, p, 5);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("final_valid", 32'(data_valid0), 0);
      chk("final_hold", 32'(data_out1), 32'(last_w));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial receive-side parity checker, the counterpart of the combinational 3-input XOR parity generator. It accepts a framed serial stream of DATA_W data bits followed by one parity bit, one bit per qualified clock. It reassembles the data word and reports it with a one-cycle valid pulse and a parity-error flag. It sits at the receive end of any serial link whose transmitter appends an XOR-generated parity bit.

## Interface
- DATA_W, 3, data bits per frame; legal range 1..32.
- ODD, 0, parity sense: 0 = even parity (XOR of data and parity = 0), 1 = odd parity (XOR = 1).

- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame start strobe; the cycle carries no data bit.
- bit_in  input  1  serial bit; sampled only when bit_valid = 1.
- bit_valid  input  1  qualifies bit_in for this cycle.
- busy  output  1  high while a frame is in progress (DATA or PARITY state).
- data_out  output  DATA_W  last completed data word, LSB received first.
- data_valid  output  1  one-cycle pulse: frame complete, data_out and parity_err valid.
- parity_err  output  1  one-cycle pulse coincident with data_valid when parity check fails; 0 otherwise.

## Operation
- Three states: IDLE, DATA, PARITY. Internal resources:
  - shift register sr[DATA_W-1:0];
  - running parity accumulator acc (1 bit);
  - bit counter cnt, width $clog2(DATA_W+1).
- IDLE:
  - busy = 0; bit_valid is ignored.
  - start = 1 → DATA, with cnt = 0, acc = 0, sr = 0.
- DATA, on each bit_valid = 1 cycle:
  - sr[cnt] <= bit_in, so the first bit lands in bit 0;
  - acc <= acc ^ bit_in;
  - cnt <= cnt + 1.
  - When the DATA_W-th bit is accepted (cnt == DATA_W-1) → PARITY.
  - Cycles with bit_valid = 0 are stalls: no state change, unbounded length.
- PARITY, on a bit_valid = 1 cycle:
  - data_out <= sr; data_valid <= 1; parity_err <= (acc ^ bit_in) != ODD;
  - → IDLE.
- start while busy (DATA or PARITY) aborts the current frame. It restarts as for IDLE + start: cnt, acc and sr are cleared and the state goes to DATA. start has priority over a simultaneous bit_valid, and that bit is discarded. The aborted frame never produces data_valid, and data_out is unchanged.
- data_out holds its value until the next completed frame. Abort and idle cycles never modify it.
- DATA_W = 1: the first accepted bit goes directly to PARITY.

## Timing
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; busy = 0; data_out = 0; data_valid = 0; parity_err = 0; sr, acc, cnt = 0.
  - Takes effect immediately, mid-frame included.
  - The first start is accepted on the first rising edge with rst_n = 1.
- busy is registered and rises the cycle after start is sampled.
- Latency: data_valid and parity_err assert in the cycle after the edge that samples the parity bit, for exactly one cycle. busy falls in that same cycle.
- Back-to-back frames: start may be asserted in the cycle where data_valid = 1, because the state is IDLE then. The minimum frame period is therefore DATA_W + 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- DATA_W=3, ODD=0:
  - Stimulus: start, then bits 1,0,1, then parity 0.
  - Required: a single data_valid pulse with data_out = 3'b101 and parity_err = 0, one cycle after the parity bit; busy low in that same cycle.
- DATA_W=3, ODD=0:
  - Stimulus: start, bits 1,1,1, parity 0.
  - Required: data_valid with data_out = 3'b111 and parity_err = 1.
  - Re-run with parity 1 → parity_err = 0.
- Stalls:
  - Stimulus: scenario 1 with 0–5 random bit_valid = 0 cycles between bits.
  - Required: identical result; busy stays 1 throughout the frame.
- Abort:
  - Stimulus: start, bits 1,1; then start together with bit_valid = 1; then bits 0,1,1, parity 0.
  - Required: exactly one data_valid, with data_out = 3'b110 and parity_err = 0.
- Reset mid-frame:
  - Stimulus: drop rst_n after 2 data bits.
  - Required: busy, data_out, data_valid and parity_err are all 0 immediately. After release, bits presented without start produce no data_valid.
- ODD=1, exhaustive:
  - Stimulus: all 8 data words, each followed by the correct odd parity bit ~^data.
  - Required: parity_err = 0 for every frame, with data_out matching the word.
  - Repeat with the parity bit inverted → parity_err = 1 for all 8. Frames are sent back-to-back at the minimum period of 5 cycles.
